// File: rtl/lcd_sequencer.sv
// HD44780 command/refresh sequencer: power-on wait, init commands, then 2x16 refreshes
// from a 32-byte character buffer, one start/done handshake per byte.
module lcd_sequencer #(
  parameter int INIT_WAIT = 750000,
  parameter int CMD_WAIT  = 2000,
  parameter int CLR_WAIT  = 82000,
  parameter int DLY_W     = 20
) (
  input  logic       iClk,
  input  logic       nRst,
  input  logic       iWrEn,
  input  logic [4:0] iWrAddr,
  input  logic [7:0] iWrData,
  input  logic       iUpdate,
  output logic       oReady,
  output logic       oBusy,
  output logic [7:0] oData,
  output logic       oRS,
  output logic       oStart,
  input  logic       iDone
);

  typedef enum logic [1:0] {PWR_WAIT, INIT, REFRESH, IDLE} top_e;
  typedef enum logic [1:0] {LOAD, ISSUE, COMPLETE, GAP} phase_e;

  // Terminal counts; gaps never shorter than two cycles so the engine's edge detector re-arms.
  localparam logic [DLY_W-1:0] INIT_TERM = (INIT_WAIT > 1) ? DLY_W'(INIT_WAIT - 1) : '0;
  localparam logic [DLY_W-1:0] CMD_TERM  = (CMD_WAIT  > 2) ? DLY_W'(CMD_WAIT  - 1) : DLY_W'(1);
  localparam logic [DLY_W-1:0] CLR_TERM  = (CLR_WAIT  > 2) ? DLY_W'(CLR_WAIT  - 1) : DLY_W'(1);

  top_e              state, state_n;
  phase_e            phase, phase_n;
  logic [5:0]        idx, idx_n;
  logic [DLY_W-1:0]  dly, dly_n, gap_term;
  logic              pending, pend_n;
  logic [7:0]        data_n, cur_byte;
  logic              rs_n, start_n, busy_n, ready_n, cur_rs;
  logic [31:0][7:0]  buf_q;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) buf_q <= {32{8'h20}};
    else if (iWrEn) buf_q[iWrAddr] <= iWrData;
  end

  // Byte for the current step; buffer read here means a same-cycle write sends the old value.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    if (state == INIT) begin
      case (idx[1:0])
        2'd0:    cur_byte = 8'h38;
        2'd1:    cur_byte = 8'h0C;
        2'd2:    cur_byte = 8'h01;
        default: cur_byte = 8'h06;
      endcase
    end else if (idx == 6'd0) begin
      cur_byte = 8'h80;
    end else if (idx <= 6'd16) begin
      cur_byte = buf_q[5'(idx - 6'd1)];
      cur_rs   = 1'b1;
    end else if (idx == 6'd17) begin
      cur_byte = 8'hC0;
    end else begin
      cur_byte = buf_q[5'(idx - 6'd2)];
      cur_rs   = 1'b1;
    end
  end

  assign gap_term = (!oRS && oData == 8'h01) ? CLR_TERM : CMD_TERM;

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    dly_n   = dly;
    pend_n  = pending | (iUpdate && state != IDLE);
    data_n  = oData;
    rs_n    = oRS;
    start_n = oStart;
    case (state)
      PWR_WAIT: begin
        if (dly >= INIT_TERM) begin
          state_n = INIT;
          phase_n = LOAD;
          idx_n   = '0;
          dly_n   = '0;
        end else begin
          dly_n = dly + DLY_W'(1);
        end
      end
      IDLE: begin
        if (iUpdate || pending) begin
          pend_n  = 1'b0;
          state_n = REFRESH;
          phase_n = LOAD;
          idx_n   = '0;
        end
      end
      default: begin
        case (phase)
          LOAD: begin
            data_n  = cur_byte;
            rs_n    = cur_rs;
            phase_n = ISSUE;
          end
          ISSUE: begin
            start_n = 1'b1;
            if (!iDone) phase_n = COMPLETE;
          end
          COMPLETE: begin
            start_n = 1'b1;
            if (iDone) begin
              start_n = 1'b0;
              phase_n = GAP;
              dly_n   = '0;
            end
          end
          GAP: begin
            start_n = 1'b0;
            if (dly >= gap_term) begin
              dly_n   = '0;
              phase_n = LOAD;
              if (state == INIT && idx == 6'd3) begin
                state_n = REFRESH;
                idx_n   = '0;
              end else if (state == REFRESH && idx == 6'd33) begin
                state_n = IDLE;
                idx_n   = '0;
              end else begin
                idx_n = idx + 6'd1;
              end
            end else begin
              dly_n = dly + DLY_W'(1);
            end
          end
        endcase
      end
    endcase
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE) && !pend_n;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state   <= PWR_WAIT;
      phase   <= LOAD;
      idx     <= '0;
      dly     <= '0;
      pending <= 1'b0;
      oData   <= 8'h00;
      oRS     <= 1'b0;
      oStart  <= 1'b0;
      oBusy   <= 1'b1;
      oReady  <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      idx     <= idx_n;
      dly     <= dly_n;
      pending <= pend_n;
      oData   <= data_n;
      oRS     <= rs_n;
      oStart  <= start_n;
      oBusy   <= busy_n;
      oReady  <= ready_n;
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: byte-engine model captures every transfer; streams are checked
// against a buffer model and the init/refresh byte order.
module tb_lcd_sequencer;
  localparam int IW = 10, CW = 4, CLW = 8;

  logic       iClk = 0, nRst = 0, iWrEn = 0, iUpdate = 0, iDone = 1;
  logic [4:0] iWrAddr = '0;
  logic [7:0] iWrData = '0;
  logic       oReady, oBusy, oRS, oStart;
  logic [7:0] oData;

  lcd_sequencer #(.INIT_WAIT(IW), .CMD_WAIT(CW), .CLR_WAIT(CLW), .DLY_W(20)) dut (
    .iClk(iClk), .nRst(nRst), .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .iUpdate(iUpdate), .oReady(oReady), .oBusy(oBusy), .oData(oData), .oRS(oRS),
    .oStart(oStart), .iDone(iDone)
  );

  always #5 iClk = ~iClk;

  int total = 0, bad = 0;
  logic [8:0] cap[$];
  logic [8:0] exp_q[$];
  logic [7:0] mbuf[32];
  int fall_at = 3;
  int stab_err = 0;
  int gap01 = -1;
  int min_gap = 1000;

  // Byte engine: done falls 3 cycles after a start rise (or fall_at), rises 17 later.
  initial begin
    int cnt, gap;
    logic prev, have_last;
    logic [8:0] last;
    cnt = -1; gap = 0; prev = 0; have_last = 0; last = '0;
    forever begin
      @(negedge iClk);
      if (!nRst) begin
        iDone = 1; cnt = -1; gap = 0; have_last = 0;
      end else begin
        if (cnt >= 0) begin
          cnt++;
          if (cnt == fall_at) iDone = 0;
          if (cnt == fall_at + 17) begin iDone = 1; cnt = -1; fall_at = 3; end
        end
        if (oStart && !prev) begin
          if (have_last) begin
            if (last == {1'b0, 8'h01}) gap01 = gap;
            if (gap < min_gap) min_gap = gap;
          end
          last = {oRS, oData};
          have_last = 1;
          cap.push_back(last);
          cnt = 0;
        end else if (oStart && {oRS, oData} !== last) begin
          stab_err++;
        end
        if (!oStart) gap++; else gap = 0;
      end
      prev = oStart;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iClk); #1;
  endtask

  function automatic void push_init();
    exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h06});
  endfunction

  function automatic void push_refresh();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mbuf[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mbuf[i]});
  endfunction

  function automatic int first_diff();
    int n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) return i;
    if (cap.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [8:0] cap_at(int i);
    return (i < cap.size()) ? cap[i] : 9'h1FF;
  endfunction

  function automatic logic [8:0] exp_at(int i);
    return (i < exp_q.size()) ? exp_q[i] : 9'h1FF;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 0;
    repeat (2) tick();
    for (int n = 0; n < 5000 && !ok; n++) begin
      if (oReady) ok = 1; else tick();
    end
  endtask

  task automatic wait_caps(input int n, output bit ok);
    ok = 0;
    for (int k = 0; k < 5000 && !ok; k++) begin
      if (cap.size() >= n) ok = 1; else tick();
    end
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    @(negedge iClk); iWrEn = 1; iWrAddr = a; iWrData = d;
    @(negedge iClk); iWrEn = 0;
    mbuf[a] = d;
  endtask

  task automatic pulse_update();
    @(negedge iClk); iUpdate = 1;
    @(negedge iClk); iUpdate = 0;
  endtask

  task automatic test_reset();
    int n; bit found;
    nRst = 0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    repeat (3) tick();
    total++;
    if ({oStart, oRS, oData, oBusy, oReady} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_outputs got start=%b rs=%b data=%h busy=%b ready=%b want 0 0 00 1 0",
                      oStart, oRS, oData, oBusy, oReady);
    end
    cap.delete();
    @(negedge iClk); nRst = 1;
    n = 0; found = 0;
    while (n < 50 && !found) begin
      tick(); n++;
      if (oStart) found = 1;
      if (n == 5) begin
        total++;
        if ({oStart, oBusy, oReady} !== 3'b010) begin
          bad++; $display("FAIL pwr_wait_outputs got start=%b busy=%b ready=%b want 0 1 0", oStart, oBusy, oReady);
        end
      end
    end
    total++;
    if (!found || n < IW || n > IW + 2) begin
      bad++; $display("FAIL first_start cycle got %0d (found=%0d) want %0d..%0d", n, found, IW, IW + 2);
    end
  endtask

  task automatic test_init();
    bit ok; int d;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL init_done got timeout want oReady=1"); end
    exp_q.delete(); push_init(); push_refresh();
    d = first_diff();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL init_stream idx=%0d got %h want %h (len %0d/%0d)", d, cap_at(d), exp_at(d), cap.size(), exp_q.size());
    end
    total++;
    if (gap01 < CLW) begin bad++; $display("FAIL clear_gap got %0d want >=%0d", gap01, CLW); end
    total++;
    if (min_gap < CW) begin bad++; $display("FAIL min_gap got %0d want >=%0d", min_gap, CW); end
    total++;
    if ({oBusy, oReady} !== 2'b01) begin bad++; $display("FAIL idle_flags got busy=%b ready=%b want 0 1", oBusy, oReady); end
  endtask

  task automatic test_hello();
    bit ok; int d;
    logic [7:0] s [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) write_buf(5'(i), s[i]);
    write_buf(5'd31, 8'h5A);
    cap.delete(); exp_q.delete(); push_refresh();
    pulse_update();
    wait_idle(ok);
    d = first_diff();
    total++;
    if (!ok || d != -1) begin
      bad++; $display("FAIL hello_stream ok=%0d idx=%0d got %h want %h (len %0d/%0d)", ok, d, cap_at(d), exp_at(d), cap.size(), exp_q.size());
    end
    total++;
    if (oReady !== 1'b1) begin bad++; $display("FAIL hello_ready got %b want 1", oReady); end
  endtask

  task automatic test_pending();
    bit ok; int d; logic [7:0] old0;
    cap.delete(); exp_q.delete();
    pulse_update();
    wait_caps(3, ok);
    old0 = mbuf[0];
    write_buf(5'd0, 8'h41);
    write_buf(5'd31, 8'h42);
    push_refresh();
    exp_q[1] = {1'b1, old0};
    pulse_update();
    repeat (5) tick();
    pulse_update();
    push_refresh();
    wait_idle(ok);
    d = first_diff();
    total++;
    if (!ok || d != -1) begin
      bad++; $display("FAIL pending_stream ok=%0d idx=%0d got %h want %h (len %0d/%0d)", ok, d, cap_at(d), exp_at(d), cap.size(), exp_q.size());
    end
    repeat (300) tick();
    total++;
    if (cap.size() != 68 || oReady !== 1'b1) begin
      bad++; $display("FAIL pending_settle got len=%0d ready=%b want 68 1", cap.size(), oReady);
    end
  endtask

  task automatic test_stall();
    bit ok; int d, held_bad; logic [8:0] held;
    cap.delete(); exp_q.delete(); push_refresh();
    pulse_update();
    wait_caps(5, ok);
    fall_at = 100;
    held = cap[4];
    held_bad = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (oStart !== 1'b1 || {oRS, oData} !== held) held_bad++;
    end
    total++;
    if (!ok || held_bad != 0) begin
      bad++; $display("FAIL stall_hold got %0d unstable cycles (ok=%0d) want 0", held_bad, ok);
    end
    wait_idle(ok);
    d = first_diff();
    total++;
    if (!ok || d != -1) begin
      bad++; $display("FAIL stall_stream ok=%0d idx=%0d got %h want %h (len %0d/%0d)", ok, d, cap_at(d), exp_at(d), cap.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok; int d, nw;
    for (int r = 0; r < 3; r++) begin
      nw = $urandom_range(1, 8);
      for (int k = 0; k < nw; k++) write_buf(5'($urandom_range(0, 31)), 8'($urandom_range(8'h21, 8'h7E)));
      cap.delete(); exp_q.delete(); push_refresh();
      pulse_update();
      wait_idle(ok);
      d = first_diff();
      total++;
      if (!ok || d != -1) begin
        bad++; $display("FAIL random_stream round=%0d ok=%0d idx=%0d got %h want %h (len %0d/%0d)", r, ok, d, cap_at(d), exp_at(d), cap.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int d;
    write_buf(5'd7, 8'h37);
    cap.delete();
    pulse_update();
    wait_caps(10, ok);
    @(negedge iClk); nRst = 0;
    #1;
    total++;
    if (!ok || {oStart, oData, oBusy, oReady} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midreset_outputs got start=%b data=%h busy=%b ready=%b want 0 00 1 0", oStart, oData, oBusy, oReady);
    end
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    gap01 = -1;
    repeat (3) tick();
    cap.delete(); exp_q.delete(); push_init(); push_refresh();
    @(negedge iClk); nRst = 1;
    wait_idle(ok);
    d = first_diff();
    total++;
    if (!ok || d != -1) begin
      bad++; $display("FAIL midreset_stream ok=%0d idx=%0d got %h want %h (len %0d/%0d)", ok, d, cap_at(d), exp_at(d), cap.size(), exp_q.size());
    end
    total++;
    if (gap01 < CLW) begin bad++; $display("FAIL midreset_clear_gap got %0d want >=%0d", gap01, CLW); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_hello();
    test_pending();
    test_stall();
    test_random();
    test_reset_mid();
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL data_stable got %0d changes while start high want 0", stab_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

Drives the byte-level HD44780 LCD write engine on the DE2 board. Runs the power-on initialisation command sequence, then refreshes a 2×16 character display from an internal 32-byte character buffer whenever a refresh is requested. It sits between user logic and the byte engine. Each transfer to the byte engine is one data/RS pair and one start/done handshake.

## Interface
- INIT_WAIT, 750000: power-on wait in cycles before the first command (15 ms at 50 MHz).
- CMD_WAIT, 2000: gap in cycles after every byte except Clear Display (40 µs).
- CLR_WAIT, 82000: gap in cycles after Clear Display (1.64 ms).
- DLY_W, 20: delay counter width. All three delay parameters must be below 2^DLY_W.
- iClk  in  1  system clock; all state changes on its rising edge.
- nRst  in  1  asynchronous active-low reset.
- iWrEn  in  1  buffer write strobe, sampled every cycle.
- iWrAddr  in  5  buffer address. 0–15 is line 1, 16–31 is line 2.
- iWrData  in  8  character code to write.
- iUpdate  in  1  refresh request, level-sampled.
- oReady  out  1  high while idle with no refresh pending.
- oBusy  out  1  high during power-on wait, init, or refresh.
- oData  out  8  byte to the byte engine.
- oRS  out  1  to the byte engine: 0 = instruction, 1 = character data.
- oStart  out  1  start request to the byte engine (rising edge triggers it).
- iDone  in  1  done level from the byte engine.

## Operation
- Reset values:
  - oStart=0, oRS=0, oData=8'h00, oBusy=1, oReady=0.
  - Pending flag=0; all 32 buffer bytes=8'h20 (space).
  - State=PWR_WAIT, delay counter=0.
- Top-level states:
  - PWR_WAIT: count INIT_WAIT cycles, then go to INIT.
  - INIT: send 8'h38, 8'h0C, 8'h01, 8'h06 with RS=0, then go to REFRESH. Reset always produces one refresh.
  - REFRESH: 34 steps, in order:
    - 8'h80 with RS=0
    - buffer[0..15] with RS=1
    - 8'hC0 with RS=0
    - buffer[16..31] with RS=1
  - IDLE: oBusy=0. If iUpdate or pending is set, clear pending and enter REFRESH. Otherwise oReady=1.
- Per-byte phases, used for every byte:
  - LOAD: drive oData/oRS. They stay stable until the next LOAD.
  - ISSUE: oStart=1. Wait for iDone==0 (engine acknowledged).
  - COMPLETE: oStart=1. Wait for iDone==1, then set oStart=0.
  - GAP: oStart=0. Count CMD_WAIT cycles, or CLR_WAIT after 8'h01, then advance to the next step.
- If iDone is already 0 on entering ISSUE (first byte after engine reset), advance the next cycle. There is no timeout; the sequencer waits indefinitely on iDone.
- Buffer writes:
  - Accepted in every state except reset; the write takes effect on the next edge.
  - The character byte is read from the buffer in LOAD. A write to an address already sent appears in the next refresh only.
  - A write to the address being loaded in the same cycle sends the old value.
- iUpdate while not in IDLE sets pending. Any number of requests collapse into one extra refresh.
- iUpdate held high in IDLE causes back-to-back refreshes.
- Reset mid-operation: all state returns to reset values immediately, including the buffer. oStart falls asynchronously.

## Timing
- oStart is high from ISSUE through the cycle iDone==1 is seen. It then stays low for at least max(CMD_WAIT,2) cycles. This guarantees the byte engine's two-stage edge detector sees a fresh rising edge.
- oData/oRS are valid one cycle before oStart rises. They hold until the GAP of that byte ends.
- Per byte: 1 (LOAD) + engine latency + 1 + gap cycles.
- Step, index and delay counters have no wrap-around. The index stops at 33 and the delay counter stops at its terminal value, then the state advances.
- oReady and oBusy are registered and change in the cycle after the state transition.

## Test plan
- Reset check (INIT_WAIT=10, CMD_WAIT=4, CLR_WAIT=8): after nRst release, outputs hold reset values. The first oStart rises at cycle 11±1.
- Init sequence, with a bench model of the byte engine (iDone falls 3 cycles after the oStart rise, rises 17 cycles later):
  - captured bytes are 38,0C,01,06 with RS=0;
  - the gap after 01 is ≥8 cycles;
  - then 80, sixteen 20s with RS=1, C0, sixteen 20s.
- Buffer refresh: write "HELLO" to addresses 0–4 and 'Z' to 31, then pulse iUpdate in IDLE. Captured stream is 80,48,45,4C,4C,4F, eleven 20s, C0, fifteen 20s, 5A. oReady returns to 1.
- Pending request: pulse iUpdate twice during a refresh. Exactly one further 34-byte refresh follows, then oReady=1.
- Stalled engine: hold iDone=1 for 100 cycles after an oStart rise. oStart stays 1 and oData stays unchanged throughout; the sequence resumes once iDone goes 0 then 1.
- Reset mid-refresh: assert nRst at byte 10. oStart=0 immediately and buffer reads 20. The full PWR_WAIT/init sequence restarts.
